// File: rtl/hdfs_mod_unit_if.sv
// rtl/hdfs_mod_unit_if.sv - command/operand in, accumulator/flags/counter out
interface hdfs_mod_unit_if #(
   parameter int WIDTH = 14,
   parameter int CMDW  = 4
);
   logic [CMDW-1:0]  d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] q0;
   logic [3:0]       q1;
   logic [3:0]       q2;

   modport master (output d0, output d1, input q0, input q1, input q2);
   modport slave  (input d0, input d1, output q0, output q1, output q2);
endinterface

// File: rtl/hdfs_mod_unit.sv
// rtl/hdfs_mod_unit.sv - 14-bit accumulator ALU with {V,C,N,Z} flags and op counter
module hdfs_mod_unit #(
   parameter int WIDTH = 14,
   parameter int CMDW  = 4
) (
   input  logic           clock,
   input  logic           reset_n,
   hdfs_mod_unit_if.slave bus
);
   localparam logic [CMDW-1:0] OP_NOP  = 4'd0,  OP_LOAD = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3;
   localparam logic [CMDW-1:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
   localparam logic [CMDW-1:0] OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_ROL = 4'd10, OP_CLR = 4'd11;
   localparam logic [CMDW-1:0] OP_INC  = 4'd12, OP_DEC  = 4'd13, OP_MAX = 4'd14, OP_CCLR = 4'd15;
   localparam logic [3:0]      SH_W    = 4'(WIDTH);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [3:0]       flag_q, flag_d;
   logic [3:0]       cnt_q, cnt_d;

   logic [WIDTH-1:0] a, opnd, res;
   logic [WIDTH:0]   sum, diff, shl_w, shr_w;
   logic [3:0]       s, rot;
   logic             c, v, upd;

   always_comb begin
      a     = acc_q;
      s     = bus.d1[3:0];
      rot   = (s >= SH_W) ? s - SH_W : s;
      opnd  = (bus.d0 == OP_INC || bus.d0 == OP_DEC) ? WIDTH'(1) : bus.d1;
      sum   = {1'b0, a} + {1'b0, opnd};
      diff  = {1'b0, a} - {1'b0, opnd};
      // Extra bit on each shift captures the last bit shifted out, which is the carry
      shl_w = {1'b0, a} << s;
      shr_w = {a, 1'b0} >> s;
      res   = acc_q;
      c     = 1'b0;
      v     = 1'b0;
      upd   = 1'b1;
      cnt_d = cnt_q + 4'd1;
      case (bus.d0)
         OP_NOP: begin
            upd   = 1'b0;
            cnt_d = cnt_q;
         end
         OP_LOAD: res = bus.d1;
         OP_ADD, OP_INC: begin
            res = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (a[WIDTH-1] == opnd[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_DEC: begin
            res = diff[WIDTH-1:0];
            c   = diff[WIDTH];
            v   = (a[WIDTH-1] != opnd[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: res = a & bus.d1;
         OP_OR:  res = a | bus.d1;
         OP_XOR: res = a ^ bus.d1;
         OP_NOT: res = ~a;
         OP_SHL: begin
            res = shl_w[WIDTH-1:0];
            c   = shl_w[WIDTH];
         end
         OP_SHR: begin
            res = shr_w[WIDTH:1];
            c   = shr_w[0];
         end
         OP_ROL: res = (a << rot) | (a >> (SH_W - rot));
         OP_CLR: res = '0;
         OP_MAX: res = (a > bus.d1) ? a : bus.d1;
         OP_CCLR: begin
            upd   = 1'b0;
            cnt_d = 4'd0;
         end
         default: begin
            upd   = 1'b0;
            cnt_d = cnt_q;
         end
      endcase
      acc_d  = upd ? res : acc_q;
      flag_d = upd ? {v, c, res[WIDTH-1], (res == '0)} : flag_q;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         acc_q  <= '0;
         flag_q <= '0;
         cnt_q  <= '0;
      end else begin
         acc_q  <= acc_d;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.q0 = acc_q;
   assign bus.q1 = flag_q;
   assign bus.q2 = cnt_q;
endmodule

// File: tb/tb_hdfs_mod_unit.sv
// tb/tb_hdfs_mod_unit.sv - directed and random checks against an arithmetic model
module tb_hdfs_mod_unit;
   logic clock;
   logic reset_n;
   int   total;
   int   bad;
   int   m_acc, m_flags, m_cnt;

   hdfs_mod_unit_if bus ();

   hdfs_mod_unit dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int sgn(input int x);
      return (x >= 8192) ? x - 16384 : x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_q0"}, 32'(bus.q0), 32'(m_acc));
      chk({tag, "_q1"}, 32'(bus.q1), 32'(m_flags));
      chk({tag, "_q2"}, 32'(bus.q2), 32'(m_cnt));
   endtask

   task automatic do_reset(input int op, input int d);
      reset_n = 1'b0;
      bus.d0  = 4'(op);
      bus.d1  = 14'(d);
      @(posedge clock);
      m_acc = 0; m_flags = 0; m_cnt = 0;
      #1;
      chk_all("reset");
   endtask

   // Model: results derived from unsigned/signed integer arithmetic on the operands
   task automatic step(input int op, input int d, input string tag);
      int a, b, s, r, c, v, k, upd, t;
      a = m_acc; b = d & 16383; s = d & 15; r = a; c = 0; v = 0; upd = 1;
      reset_n = 1'b1;
      bus.d0  = 4'(op);
      bus.d1  = 14'(b);
      @(posedge clock);
      case (op)
         0: upd = 0;
         1: r = b;
         2, 12: begin
            if (op == 12) b = 1;
            r = (a + b) % 16384; c = int'(a + b > 16383);
            t = sgn(a) + sgn(b); v = int'(t > 8191 || t < -8192);
         end
         3, 13: begin
            if (op == 13) b = 1;
            r = (a - b + 16384) % 16384; c = int'(a < b);
            t = sgn(a) - sgn(b); v = int'(t > 8191 || t < -8192);
         end
         4: r = a & b;
         5: r = a | b;
         6: r = a ^ b;
         7: r = 16383 - a;
         8: begin
            r = (s >= 14) ? 0 : (a * (1 << s)) % 16384;
            c = (s >= 1 && s <= 14) ? (a >> (14 - s)) & 1 : 0;
         end
         9: begin
            r = (s >= 14) ? 0 : a / (1 << s);
            c = (s >= 1 && s <= 14) ? (a >> (s - 1)) & 1 : 0;
         end
         10: begin
            k = s % 14;
            r = ((a * (1 << k)) % 16384) + a / (1 << (14 - k));
         end
         11: r = 0;
         14: r = (a > b) ? a : b;
         default: upd = 0;
      endcase
      if (op == 15) m_cnt = 0;
      else if (op != 0) m_cnt = (m_cnt + 1) % 16;
      if (upd == 1) begin
         m_acc   = r;
         m_flags = v * 8 + c * 4 + ((r >> 13) & 1) * 2 + int'(r == 0);
      end
      #1;
      chk_all(tag);
   endtask

   initial begin
      int op, d, sel;
      total = 0; bad = 0;
      m_acc = 0; m_flags = 0; m_cnt = 0;
      reset_n = 1'b0; bus.d0 = 4'd0; bus.d1 = 14'd0;

      do_reset(2, 'h1234);
      do_reset(2, 'h1234);
      chk("rst_q0", 32'(bus.q0), 32'h0);
      step(0, 'h1234, "nop_hold");
      chk("nop_q2", 32'(bus.q2), 32'd0);

      step(1, 'h3FFF, "load");
      step(2, 'h0001, "carry");
      chk("carry_q0", 32'(bus.q0), 32'h0000);
      chk("carry_q1", 32'(bus.q1), 32'h5);
      chk("carry_q2", 32'(bus.q2), 32'd2);

      step(1, 'h0000, "load");
      step(3, 'h0001, "borrow");
      chk("borrow_q0", 32'(bus.q0), 32'h3FFF);
      chk("borrow_q1", 32'(bus.q1), 32'h6);
      step(12, 0, "inc");
      chk("inc_q0", 32'(bus.q0), 32'h0000);
      chk("inc_q1", 32'(bus.q1), 32'h5);

      step(1, 'h1FFF, "load");
      step(2, 'h0001, "ovf");
      chk("ovf_q0", 32'(bus.q0), 32'h2000);
      chk("ovf_q1", 32'(bus.q1), 32'hA);

      step(1, 'h0003, "load");
      step(8, 13, "shl13");
      chk("shl13_q0", 32'(bus.q0), 32'h2000);
      chk("shl13_q1", 32'(bus.q1), 32'h6);
      step(8, 15, "shl15");
      chk("shl15_q0", 32'(bus.q0), 32'h0000);
      chk("shl15_q1", 32'(bus.q1), 32'h1);
      step(1, 'h2001, "load");
      step(10, 15, "rol15");
      chk("rol15_q0", 32'(bus.q0), 32'h0003);
      chk("rol15_q1", 32'(bus.q1), 32'h0);
      step(1, 'h2001, "load");
      step(9, 14, "shr14");
      step(1, 'h2001, "load");
      step(8, 14, "shl14");
      step(10, 14, "rol14");

      do_reset(0, 0);
      for (int i = 0; i < 16; i++) step(2, 0, "cnt_add");
      chk("cnt_wrap", 32'(bus.q2), 32'd0);
      step(0, 0, "cnt_nop");
      chk("cnt_nop_q2", 32'(bus.q2), 32'd0);
      step(1, 'h0155, "cnt_op");
      step(6, 'h00FF, "cnt_op");
      step(14, 'h0AAA, "cnt_op");
      chk("cnt3_q2", 32'(bus.q2), 32'd3);
      step(15, 'h3FFF, "cntclr");
      chk("cntclr_q2", 32'(bus.q2), 32'd0);
      chk("cntclr_q0", 32'(bus.q0), 32'h0AAA);

      for (int i = 0; i < 600; i++) begin
         op  = int'($urandom_range(0, 15));
         sel = int'($urandom_range(0, 7));
         case (sel)
            0: d = 'h3FFF;
            1: d = 'h0000;
            2: d = 'h2000;
            3: d = 'h1FFF;
            4: d = int'($urandom_range(0, 15));
            default: d = int'($urandom_range(0, 16383));
         endcase
         if ($urandom_range(0, 49) == 0) do_reset(op, d);
         else step(op, d, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
